// File: rtl/mux_pipe_pkg.sv
// rtl/mux_pipe_pkg.sv - shared ALU result-path constants and helpers
package mux_pipe_pkg;

    // Out-of-range selects return this bit replicated across the word.
    localparam logic MUX_ERR_DATA = 1'b0;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_pipe_skid_buf.sv
// rtl/mux_pipe_skid_buf.sv - generic 2-entry valid/ready skid buffer
module mux_pipe_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_main_valid;
    logic [W-1:0] r_main_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;
    logic         r_in_ready;

    logic         w_acc;
    logic         w_emit;
    logic         w_main_valid_nxt;
    logic [W-1:0] w_main_data_nxt;
    logic         w_skid_valid_nxt;
    logic [W-1:0] w_skid_data_nxt;
    logic         w_in_ready_nxt;

    assign w_acc  = in_valid && r_in_ready;
    assign w_emit = r_main_valid && out_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (r_skid_valid) begin
            // in_ready is low here, so only the drain of the skid entry matters
            if (w_emit) begin
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (w_acc) begin
            if (!r_main_valid || w_emit) begin
                w_main_data_nxt  = in_data;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_skid_data_nxt  = in_data;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (w_emit) begin
            w_main_valid_nxt = 1'b0;
        end
        w_in_ready_nxt = !w_skid_valid_nxt;
    end

    // in_ready is a plain register so it never depends on in_valid combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_in_ready   <= w_in_ready_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

endmodule

// File: rtl/mux_pipe.sv
// rtl/mux_pipe.sv - registered N-way word selector with skid-buffered output
module mux_pipe
    import mux_pipe_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  N_IN  = 8,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err
);

    logic [WIDTH-1:0] w_word;
    logic             w_err;
    logic [WIDTH:0]   w_payload;
    logic [WIDTH:0]   w_out_payload;

    // Non-power-of-two N_IN leaves unmatched select codes, which fall through as errors.
    always_comb begin
        w_word = {WIDTH{MUX_ERR_DATA}};
        w_err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == k[SEL_W-1:0]) begin
                w_word = in_data[k*WIDTH +: WIDTH];
                w_err  = 1'b0;
            end
        end
    end

    assign w_payload = {w_err, w_word};

    mux_pipe_skid_buf #(
        .W(WIDTH + 1)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign out_err  = w_out_payload[WIDTH];
    assign out_data = w_out_payload[WIDTH-1:0];

endmodule

// File: tb/tb_mux_pipe.sv
// tb/tb_mux_pipe.sv - self-checking bench for mux_pipe (N_IN=8 and N_IN=5 instances)
module tb_mux_pipe;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    logic          a_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [2:0]    a_sel;
    logic [255:0]  a_data;
    logic [31:0]   a_out_data;

    logic          b_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [2:0]    b_sel;
    logic [159:0]  b_data;
    logic [31:0]   b_out_data;

    int checks   = 0;
    int failures = 0;

    logic [32:0] qa[$];
    logic [32:0] qb[$];

    typedef struct {
        bit          use_b;
        logic [2:0]  sel;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tv[13];

    always #5 clk = ~clk;

    mux_pipe #(.WIDTH(32), .N_IN(8)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_valid), .in_ready(a_in_ready), .in_data(a_data), .in_sel(a_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err)
    );

    mux_pipe #(.WIDTH(32), .N_IN(5)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(b_valid), .in_ready(b_in_ready), .in_data(b_data), .in_sel(b_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] ref_sel(input logic [2:0] sel, input int n, input logic [31:0] base);
        if (int'(sel) < n) return {1'b0, base + 32'(sel)};
        return {1'b1, 32'h0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are sampled mid-cycle; inputs only change just after a rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("sb_a_unexpected", {a_out_err, a_out_data}, 64'h1_FFFF_FFFF);
                else chk("sb_a_data", {a_out_err, a_out_data}, qa.pop_front());
            end
            if (flush) qa.delete();
            else if (a_valid && a_in_ready) qa.push_back(ref_sel(a_sel, 8, 32'h1000_0000));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) chk("sb_b_unexpected", {b_out_err, b_out_data}, 64'h1_FFFF_FFFF);
                else chk("sb_b_data", {b_out_err, b_out_data}, qb.pop_front());
            end
            if (flush) qb.delete();
            else if (b_valid && b_in_ready) qb.push_back(ref_sel(b_sel, 5, 32'h2000_0000));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 8; k++) a_data[k*32 +: 32] = 32'h1000_0000 + k;
        for (int k = 0; k < 5; k++) b_data[k*32 +: 32] = 32'h2000_0000 + k;
        for (int i = 0; i < 8; i++) tv[i] = '{1'b0, 3'(i), 32'h1000_0000 + i, 1'b0};
        tv[8]  = '{1'b1, 3'd6, 32'h0,         1'b1};
        tv[9]  = '{1'b1, 3'd4, 32'h2000_0004, 1'b0};
        tv[10] = '{1'b1, 3'd7, 32'h0,         1'b1};
        tv[11] = '{1'b1, 3'd5, 32'h0,         1'b1};
        tv[12] = '{1'b1, 3'd0, 32'h2000_0000, 1'b0};

        // Reset with a request pending
        rst_n = 1'b0; flush = 1'b0;
        a_valid = 1'b1; a_sel = 3'd3; a_out_ready = 1'b1;
        b_valid = 1'b1; b_sel = 3'd2; b_out_ready = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_data", a_out_data, 32'h0);
        chk("rst_out_err", a_out_err, 1'b0);
        chk("rst_b_out_valid", b_out_valid, 1'b0);
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        step();
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_b_in_ready", b_in_ready, 1'b1);

        // Back-to-back stream on both instances, one cycle latency
        for (int i = 0; i < 13; i++) begin
            a_valid = !tv[i].use_b; a_sel = tv[i].sel;
            b_valid =  tv[i].use_b; b_sel = tv[i].sel;
            step();
            if (tv[i].use_b) begin
                chk($sformatf("vec%0d_valid", i), b_out_valid, 1'b1);
                chk($sformatf("vec%0d_data", i), b_out_data, tv[i].exp_data);
                chk($sformatf("vec%0d_err", i), b_out_err, tv[i].exp_err);
            end else begin
                chk($sformatf("vec%0d_valid", i), a_out_valid, 1'b1);
                chk($sformatf("vec%0d_data", i), a_out_data, tv[i].exp_data);
                chk($sformatf("vec%0d_in_ready", i), a_in_ready, 1'b1);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        chk("drain_a_valid", a_out_valid, 1'b0);
        chk("drain_b_valid", b_out_valid, 1'b0);

        // Backpressure fills the skid entry
        a_out_ready = 1'b0; a_valid = 1'b1; a_sel = 3'd1;
        step();
        chk("bp_first_data", a_out_data, 32'h1000_0001);
        a_sel = 3'd2;
        step();
        chk("bp_in_ready_low", a_in_ready, 1'b0);
        a_sel = 3'd3;
        step();
        chk("bp_stall_data", a_out_data, 32'h1000_0001);
        chk("bp_stall_valid", a_out_valid, 1'b1);
        a_valid = 1'b0; a_out_ready = 1'b1;
        step();
        chk("bp_second_data", a_out_data, 32'h1000_0002);
        chk("bp_in_ready_back", a_in_ready, 1'b1);
        step();
        chk("bp_drained", a_out_valid, 1'b0);

        // Flush with both entries full
        a_out_ready = 1'b0; a_valid = 1'b1; a_sel = 3'd4;
        step();
        a_sel = 3'd5;
        step();
        flush = 1'b1; a_sel = 3'd6; a_out_ready = 1'b1;
        step();
        flush = 1'b0; a_valid = 1'b0;
        chk("flush_full_valid", a_out_valid, 1'b0);
        chk("flush_full_in_ready", a_in_ready, 1'b1);
        step();
        chk("flush_full_quiet", a_out_valid, 1'b0);

        // Flush racing an accept while the skid entry is free
        a_out_ready = 1'b0; a_valid = 1'b1; a_sel = 3'd1;
        step();
        flush = 1'b1; a_sel = 3'd7; a_out_ready = 1'b1;
        step();
        flush = 1'b0; a_valid = 1'b0;
        chk("flush_acc_valid", a_out_valid, 1'b0);
        chk("flush_acc_in_ready", a_in_ready, 1'b1);
        step();
        chk("flush_acc_quiet", a_out_valid, 1'b0);

        // Asynchronous reset while stalled with the skid entry full
        a_out_ready = 1'b0; a_valid = 1'b1; a_sel = 3'd2;
        step();
        a_sel = 3'd3;
        step();
        a_valid = 1'b0;
        chk("ars_stalled", a_in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ars_out_valid", a_out_valid, 1'b0);
        chk("ars_out_data", a_out_data, 32'h0);
        chk("ars_in_ready", a_in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; a_out_ready = 1'b1;
        step();
        chk("ars_in_ready_back", a_in_ready, 1'b1);
        a_valid = 1'b1; a_sel = 3'd5;
        step();
        a_valid = 1'b0;
        chk("ars_first_valid", a_out_valid, 1'b1);
        chk("ars_first_data", a_out_data, 32'h1000_0005);
        step();
        chk("ars_first_drained", a_out_valid, 1'b0);

        step();
        chk("sb_a_empty", 64'(qa.size()), 64'h0);
        chk("sb_b_empty", 64'(qb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised, registered N-way word selector for the ALU result path; successor to the fixed 8-input combinational selector.
- Selects one of N_IN input words by binary select, flags out-of-range selects, and registers the result.
- The registered result passes through a 2-entry skid stage with valid/ready handshake so the ALU-to-writeback path can stall without dropping results.
- Sits between ALU functional units (inputs) and the writeback/forwarding stage (output).

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- N_IN, 8, number of input words (>=2; need not be a power of two).
- SEL_W, $clog2(N_IN), select width; derived, not overridden.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all buffered results.
- in_valid  input  1  in_data/in_sel carry a valid request.
- in_ready  output  1  block can accept a request this cycle.
- in_data  input  N_IN*WIDTH  packed words; word k is in_data[k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary index of the selected word.
- out_valid  output  1  out_data/out_err hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  selected word.
- out_err  output  1  result came from an out-of-range in_sel.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_err=0.
  - Both skid entries empty.
  - in_ready=1 from the first edge after release.
- Selection (combinational, before the register):
  - in_sel < N_IN: word = word[in_sel], err = 0.
  - in_sel >= N_IN: word = 0, err = 1.
- Handshake:
  - Accept when in_valid && in_ready. Emit when out_valid && out_ready.
  - in_valid and in_sel are never combinationally fed to in_ready.
  - A valid request is never lost or duplicated.
- Storage:
  - Main entry drives out_data, out_err and out_valid.
  - Skid entry holds one extra result.
  - in_ready = !skid_valid, registered.
- Latency: 1 cycle. A request accepted at edge t appears on the outputs after edge t when the main entry is empty or emptying.
- Per-edge transitions (A = accept, E = emit):
  - Main empty, A: main <= new.
  - Main full, A and E, skid empty: main <= new.
  - Main full, A, not E: skid <= new; in_ready drops to 0 next cycle.
  - Skid full, E: main <= skid, skid cleared, in_ready=1 next cycle. A cannot occur in this state.
  - E only: main cleared (out_valid=0); out_data keeps its last value.
- Throughput: one result per cycle sustained while out_ready=1.
- Stall: out_data and out_err stay stable while out_valid && !out_ready.
- Flush:
  - Clears both entries at the edge; out_valid=0 and in_ready=1 next cycle.
  - Flush wins over a simultaneous accept: that request is dropped, but still counts as handshaken.
  - Flush wins over a simultaneous emit: that emit is the last.
- Reset mid-operation: all state discarded immediately, regardless of handshake state.
- Arithmetic: no width extension; out_data is exactly WIDTH bits.

Decomposition:
- Shared ALU package holds:
  - the select-width helper (clog2 wrapper, minimum 1);
  - a named constant MUX_ERR_DATA = '0 for out-of-range data.
- One sub-module is natural: skid_buf.
  - Generic 2-entry valid/ready buffer, payload width WIDTH+1 (data plus err).
  - mux_pipe = combinational select + skid_buf instance.

Test Plan:
1. Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_data=0, out_err=0; in_ready=1 one cycle after release.
2. Stream: WIDTH=32, N_IN=8, word k = 0x1000_0000+k, out_ready=1, in_sel=0..7 over consecutive cycles -> out_data 0x1000_0000..0x1000_0007 one cycle later each, no bubbles, out_err=0.
3. Out-of-range: N_IN=5, in_sel=6 -> out_data=0, out_err=1; then in_sel=4 -> word 4, out_err=0.
4. Backpressure: out_ready=0, send sel=1 then sel=2 -> in_ready=0 after the second accept, out_data=word1 stable; raise out_ready -> word1 then word2 on consecutive cycles, in_ready=1 again.
5. Flush race: buffer full, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, flushed request never appears.
6. Async reset mid-stall: skid full, drop rst_n between edges -> outputs clear immediately; first request after release emerges 1 cycle after acceptance.
